// File: rtl/seq_multiplier_radix.sv
// Radix-2^BITS_PER_CYCLE sequential shift-add multiplier, signed/unsigned per op.
// Ports: clk, rst (async high), start, signedMode, multiplier, multiplicand in;
//        product, productDone, busy, cycles out. Option macro: MULT_CONST_TIME_EN.
module seq_multiplier_radix #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  localparam int N             = WIDTH / BITS_PER_CYCLE,
  localparam int CW            = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signedMode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               productDone,
  output logic               busy,
  output logic [CW-1:0]      cycles
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] NCNT = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, stateNext;

  logic [WIDTH-1:0]          mplier;
  logic [PW-1:0]             mcandSh;
  logic [PW-1:0]             acc;
  logic [CW-1:0]             iter;
  logic                      resultSign;

  logic [WIDTH-1:0]          magMr;
  logic [WIDTH-1:0]          magMd;
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [PW-1:0]             partial;
  logic [PW-1:0]             accNext;
  logic [WIDTH-1:0]          mplierNext;
  logic [CW-1:0]             iterNext;
  logic                      finish;

  // Negation of the most negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  always_comb begin
    magMr = multiplier;
    magMd = multiplicand;
    if (signedMode && multiplier[WIDTH-1]) magMr = -multiplier;
    if (signedMode && multiplicand[WIDTH-1]) magMd = -multiplicand;
  end

  // mcandSh carries the multiplicand pre-shifted by BITS_PER_CYCLE*iter.
  always_comb begin
    digit      = mplier[BITS_PER_CYCLE-1:0];
    partial    = {{(PW-BITS_PER_CYCLE){1'b0}}, digit} * mcandSh;
    accNext    = acc + partial;
    mplierNext = mplier >> BITS_PER_CYCLE;
    iterNext   = iter + 1'b1;
`ifdef MULT_CONST_TIME_EN
    finish     = (iterNext == NCNT);
`else
    finish     = (iterNext == NCNT) || (mplierNext == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (finish) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mplier     <= '0;
      mcandSh    <= '0;
      acc        <= '0;
      iter       <= '0;
      resultSign <= 1'b0;
      product    <= '0;
      cycles     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mplier     <= magMr;
            mcandSh    <= {{WIDTH{1'b0}}, magMd};
            acc        <= '0;
            iter       <= '0;
            resultSign <= signedMode &
                          (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
          end
        end
        RUN: begin
          acc     <= accNext;
          mplier  <= mplierNext;
          mcandSh <= mcandSh << BITS_PER_CYCLE;
          iter    <= iterNext;
          if (finish) begin
            product <= resultSign ? -accNext : accNext;
            cycles  <= iterNext;
          end
        end
        default: ;
      endcase
    end
  end

  assign productDone = (state == DONE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_seq_multiplier_radix.sv
// Directed bench for seq_multiplier_radix at WIDTH=8 with BPC=1 and BPC=2.
// Instances A/B (BPC=1) run paired starts; C (BPC=2) covers signed radix-4.
module tb_seq_multiplier_radix;

`ifdef MULT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stA = 0, sgA = 0, stB = 0, sgB = 0, stC = 0, sgC = 0;
  logic [7:0]  mrA = 0, mdA = 0, mrB = 0, mdB = 0, mrC = 0, mdC = 0;
  logic [15:0] prA, prB, prC;
  logic        dnA, dnB, dnC, byA, byB, byC;
  logic [3:0]  cyA, cyB;
  logic [2:0]  cyC;

  int tests = 0;
  int fails = 0;

  seq_multiplier_radix #(.WIDTH(8), .BITS_PER_CYCLE(1)) uA (
    .clk(clk), .rst(rst), .start(stA), .signedMode(sgA),
    .multiplier(mrA), .multiplicand(mdA), .product(prA),
    .productDone(dnA), .busy(byA), .cycles(cyA));

  seq_multiplier_radix #(.WIDTH(8), .BITS_PER_CYCLE(1)) uB (
    .clk(clk), .rst(rst), .start(stB), .signedMode(sgB),
    .multiplier(mrB), .multiplicand(mdB), .product(prB),
    .productDone(dnB), .busy(byB), .cycles(cyB));

  seq_multiplier_radix #(.WIDTH(8), .BITS_PER_CYCLE(2)) uC (
    .clk(clk), .rst(rst), .start(stC), .signedMode(sgC),
    .multiplier(mrC), .multiplicand(mdC), .product(prC),
    .productDone(dnC), .busy(byC), .cycles(cyC));

  function automatic int kSel(input int early, input int full);
    return CT ? full : early;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = A, 2 = C. Returns edges from accept to productDone, -1 on timeout.
  task automatic runOp(input int which, input logic s, input logic [7:0] mr,
                       input logic [7:0] md, output int lat);
    @(negedge clk);
    if (which == 0) begin stA = 1; sgA = s; mrA = mr; mdA = md; end
    else begin stC = 1; sgC = s; mrC = mr; mdC = md; end
    @(posedge clk);
    @(negedge clk);
    stA = 0; stC = 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && dnA) || (which == 2 && dnC)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic afterDone(input string tag, input logic dn, input logic by);
    check({tag, "_doneOff"}, {62'd0, dn, by}, 64'd0);
  endtask

  int lat, la, lb, cnt;

  initial begin
    #1;
    check("rst_prA", prA, 0);
    check("rst_flags", {dnA, byA, dnC, byC}, 0);
    check("rst_cyA", cyA, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    runOp(0, 0, 8'd11, 8'd13, lat);
    check("u13x11_lat", lat, kSel(4, 8));
    check("u13x11_prod", prA, 16'd143);
    check("u13x11_cyc", cyA, kSel(4, 8));
    @(posedge clk); #1;
    afterDone("u13x11", dnA, byA);

    runOp(2, 1, 8'h80, 8'h80, lat);
    check("sN128_lat", lat, 4);
    check("sN128_prod", prC, 16'h4000);
    check("sN128_cyc", cyC, 4);
    @(posedge clk); #1;
    afterDone("sN128", dnC, byC);

    runOp(2, 1, 8'hFD, 8'd5, lat);
    check("sN3x5_lat", lat, kSel(1, 4));
    check("sN3x5_prod", prC, 16'hFFF1);
    check("sN3x5_cyc", cyC, kSel(1, 4));

    @(negedge clk);
    stA = 1; sgA = 0; mrA = 8'h00; mdA = 8'h5A;
    stB = 1; sgB = 0; mrB = 8'hFF; mdB = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    stA = 0; stB = 0;
    la = -1; lb = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dnA && la < 0) la = i;
      if (dnB && lb < 0) lb = i;
      if (la >= 0 && lb >= 0) break;
    end
    check("pair_latA", la, kSel(1, 8));
    check("pair_latB", lb, 8);
    check("pair_cycA", cyA, kSel(1, 8));
    check("pair_cycB", cyB, 8);
    check("pair_prodA", prA, 0);
    check("pair_prodB", prB, 16'h59A6);
    repeat (2) @(posedge clk);

    @(negedge clk);
    stA = 1; sgA = 0; mrA = 8'd11; mdA = 8'd13;
    @(posedge clk);
    cnt = 0;
    for (int i = 1; i <= kSel(4, 8) + 1; i++) begin
      @(negedge clk);
      mrA = 8'h00; mdA = 8'hFF; sgA = 1;
      @(posedge clk); #1;
      if (dnA) cnt++;
    end
    @(negedge clk);
    stA = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (dnA) cnt++;
    end
    check("spam_doneCnt", cnt, 1);
    check("spam_prod", prA, 16'd143);
    check("spam_cyc", cyA, kSel(4, 8));

    @(negedge clk);
    stA = 1; sgA = 0; mrA = 8'hFF; mdA = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    stA = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_prod", prA, 0);
    check("arst_flags", {dnA, byA}, 0);
    check("arst_cyc", cyA, 0);
    cnt = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dnA || byA) cnt++;
    end
    @(negedge clk);
    rst = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (dnA || byA) cnt++;
    end
    check("arst_noStray", cnt, 0);

    runOp(0, 0, 8'd9, 8'd7, lat);
    check("u7x9_lat", lat, kSel(4, 8));
    check("u7x9_prod", prA, 16'd63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_radix.md
# seq_multiplier_radix

Parametrised sequential multiplier: radix-2^BITS_PER_CYCLE shift-add core with signed/unsigned mode selected per operation, a cycle-count output and optional data-independent (constant-time) latency. Successor to the fixed radix-2 unsigned multiplier instantiated by the property testers. It drops into the same tester harnesses, where paired instances are compared for timing leakage and algebraic properties.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; must divide WIDTH (1, 2, 4 legal).
- N (derived), WIDTH/BITS_PER_CYCLE, maximum RUN cycles.

- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signedMode  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands.
- multiplier  in  WIDTH  operand scanned BITS_PER_CYCLE bits per cycle, LSB first.
- multiplicand  in  WIDTH  operand added per digit.
- product  out  2*WIDTH  result; held from productDone until the next accepted start.
- productDone  out  1  single-cycle pulse when product becomes valid.
- busy  out  1  high in RUN and DONE.
- cycles  out  $clog2(N+1)  RUN cycles used by the last operation; updated with productDone.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: at an edge with start=1, go to RUN.
  - Latch |multiplier|, |multiplicand| and resultSign = signedMode & (msb(multiplier) ^ msb(multiplicand)).
  - In unsigned mode the magnitudes are the raw operands.
  - Clear the accumulator and the iteration counter.
- RUN, each edge:
  - accumulator += digit * multiplicand << (BITS_PER_CYCLE*iter), where digit is the low BITS_PER_CYCLE bits of the shifting multiplier register.
  - Shift the multiplier right by BITS_PER_CYCLE.
  - Increment iter.
- Finalisation condition:
  - Without the macro: iter reaches N, or the shifted multiplier becomes zero (early termination).
  - With the macro: iter reaches N only.
- Finalisation edge:
  - product = resultSign ? -(final accumulator) : final accumulator, computed from the same edge's accumulation.
  - cycles = iter count including this edge.
  - Next state DONE.
- DONE: productDone=1 for this cycle only; next edge goes to IDLE.
- Arithmetic: magnitude product of two WIDTH-bit values fits 2*WIDTH bits. The signed extreme -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2) is representable; no overflow flag.
- start while busy (RUN or DONE) is ignored; it is not queued.
- Operand and signedMode changes after acceptance have no effect.

## Timing
- Reset (async, immediate): state IDLE, product=0, productDone=0, busy=0, cycles=0, internal registers 0.
- rst asserted mid-RUN aborts the operation. No productDone follows; product reads 0.
- Accept edge E0. Finalisation at edge Ek, where 1 ≤ k ≤ N. productDone is high between Ek and Ek+1. busy drops after Ek+1.
- Earliest next accept is edge Ek+2, so back-to-back throughput is one op per k+2 cycles.
- Zero multiplier: k=1 without the macro, k=N with it.
- Latency depends only on the multiplier magnitude (highest nonzero digit), never on the multiplicand.

## Configuration
- MULT_CONST_TIME_EN defined: early termination disabled.
  - Every operation takes exactly N RUN cycles and cycles always reads N.
  - Two instances given the same start always raise productDone on the same cycle, so the tester's timing-leak check holds for any operands.
- Undefined: early termination is active.
  - k = max(1, ceil(index of highest nonzero bit of |multiplier|, plus 1, divided by BITS_PER_CYCLE)).

## Test plan
- WIDTH=8, BPC=1, unsigned, macro off: 13*11.
  - Response: product=143; k=4 (|multiplier|=11 uses 4 bits); cycles=4; productDone one cycle, 4 edges after accept.
- WIDTH=8, BPC=2, signed: -128 * -128.
  - Response: product=0x4000; cycles=4.
- Same configuration, signed: -3 * 5.
  - Response: product=0xFFF1 (-15).
- Macro on, WIDTH=8, BPC=1: multiplier 0 and multiplier 0xFF on two instances started together.
  - Response: productDone coincident on both after 8 RUN cycles; cycles=8 on both.
  - Macro off: k=1 versus k=8.
- start pulsed every cycle during an operation, and also in the DONE cycle.
  - Response: exactly one productDone; product unchanged by the extra starts.
- rst raised asynchronously mid-RUN, then released and a new op 7*9 issued.
  - Response: outputs go to 0 immediately; no stray productDone; new op returns 63.
